// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-lane RAM between fetch and load/store ports; data priority with fetch starvation limit.
// Ports: clk/reset_n; if_req/if_addr -> if_gnt (comb), if_rvalid/if_rdata (registered);
// d_req/d_we/d_be/d_addr/d_wdata -> d_gnt (comb), d_rvalid/d_rdata (registered);
// ram_address/ram_write_enable/ram_memory_in drive the RAM, ram_memory_out is its combinational read.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic [ADDR_WIDTH-3:0] ram_address,
  output logic [3:0]            ram_write_enable,
  output logic [31:0]           ram_memory_in,
  input  logic [31:0]           ram_memory_out
);
  logic [3:0] starve_cnt;
  logic       force_if;
  assign force_if = starve_cnt >= 4'(STARVE_LIMIT);
  // grants are gated by reset_n so nothing reaches the RAM while reset is held
  assign d_gnt  = reset_n && d_req && !(if_req && force_if);
  assign if_gnt = reset_n && if_req && !d_gnt;
  assign ram_address      = d_gnt ? d_addr[ADDR_WIDTH-1:2] : if_addr[ADDR_WIDTH-1:2];
  assign ram_write_enable = (d_gnt && d_we) ? d_be : 4'b0000;
  assign ram_memory_in    = d_wdata;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      starve_cnt <= (!if_req || if_gnt) ? 4'd0 : (starve_cnt == 4'd15 ? 4'd15 : starve_cnt + 4'd1);
      if_rvalid  <= if_gnt;
      d_rvalid   <= d_gnt;
      // d_rdata takes the pre-write word because the RAM read is combinational in the grant cycle
      if (if_gnt) if_rdata <= ram_memory_out;
      if (d_gnt) d_rdata <= ram_memory_out;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector and sequence bench for mem_arbiter with a behavioural byte-lane RAM.
module tb_mem_arbiter;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        if_req = 0;
  logic [11:0] if_addr = 0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 0, d_we = 0;
  logic [3:0]  d_be = 0;
  logic [11:0] d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [9:0]  ram_address;
  logic [3:0]  ram_write_enable;
  logic [31:0] ram_memory_in, ram_memory_out;
  int checks = 0, failures = 0;

  mem_arbiter #(.ADDR_WIDTH(12), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_address(ram_address), .ram_write_enable(ram_write_enable),
    .ram_memory_in(ram_memory_in), .ram_memory_out(ram_memory_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        init_done = 0;
  assign ram_memory_out = mem[ram_address];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h010] <= 32'hDEADBEEF;
      mem[10'h004] <= 32'h11223344;
      init_done <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_write_enable[b]) mem[ram_address][8*b +: 8] <= ram_memory_in[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [11:0] ia, input logic dr, input logic we,
                       input logic [3:0] be, input logic [11:0] da, input logic [31:0] wd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
  endtask

  typedef struct {
    logic        ir;
    logic [11:0] ia;
    logic        dr, we;
    logic [3:0]  be;
    logic [11:0] da;
    logic [31:0] wd;
    logic        e_ig, e_dg;
    logic [9:0]  e_ra;
    logic [3:0]  e_we;
    logic        e_iv, e_dv;
    logic [31:0] e_ird, e_drd;
  } vec_t;

  vec_t v [9];

  initial begin
    // each row: stimulus, expected comb outputs this cycle, expected response to the previous row
    v[0] = '{1, 12'h040, 0, 0, 4'h0, 12'h000, 32'h0,        1, 0, 10'h010, 4'h0, 0, 0, 32'h0,        32'h0};
    v[1] = '{0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0,        0, 0, 10'h000, 4'h0, 1, 0, 32'hDEADBEEF, 32'h0};
    v[2] = '{0, 12'h000, 1, 1, 4'h4, 12'h012, 32'h00AA0000, 0, 1, 10'h004, 4'h4, 0, 0, 32'hDEADBEEF, 32'h0};
    v[3] = '{0, 12'h000, 1, 0, 4'h0, 12'h010, 32'h0,        0, 1, 10'h004, 4'h0, 0, 1, 32'hDEADBEEF, 32'h11223344};
    v[4] = '{0, 12'h000, 1, 1, 4'hF, 12'h080, 32'h00000013, 0, 1, 10'h020, 4'hF, 0, 1, 32'hDEADBEEF, 32'h11AA3344};
    v[5] = '{1, 12'h080, 0, 0, 4'h0, 12'h000, 32'h0,        1, 0, 10'h020, 4'h0, 0, 1, 32'hDEADBEEF, 32'h0};
    v[6] = '{0, 12'h000, 1, 1, 4'h0, 12'h040, 32'hFFFFFFFF, 0, 1, 10'h010, 4'h0, 1, 0, 32'h00000013, 32'h0};
    v[7] = '{1, 12'h040, 0, 0, 4'h0, 12'h000, 32'h0,        1, 0, 10'h010, 4'h0, 0, 1, 32'h00000013, 32'hDEADBEEF};
    v[8] = '{0, 12'h3FC, 0, 0, 4'h0, 12'h000, 32'h0,        0, 0, 10'h0FF, 4'h0, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF};

    // reset held 3 cycles with a fetch request present: no grant, no write, no response
    drive(1, 12'h040, 1, 1, 4'hF, 12'h040, 32'h12345678);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #5;
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_we", 32'(ram_write_enable), 0);
      chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
    end
    @(posedge clk); #1;
    drive(0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0);
    reset_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #5;
      chk("idle_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
      chk("idle_rdata", if_rdata | d_rdata, 0);
      chk("idle_we", 32'(ram_write_enable), 0);
    end

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(v[i].ir, v[i].ia, v[i].dr, v[i].we, v[i].be, v[i].da, v[i].wd);
      #4;
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(v[i].e_ig));
      chk($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(v[i].e_dg));
      chk($sformatf("v%0d_ram_addr", i), 32'(ram_address), 32'(v[i].e_ra));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_write_enable), 32'(v[i].e_we));
      chk($sformatf("v%0d_ram_in", i), ram_memory_in, v[i].wd);
      chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(v[i].e_iv));
      chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(v[i].e_dv));
      chk($sformatf("v%0d_if_rdata", i), if_rdata, v[i].e_ird);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, v[i].e_drd);
    end

    // both requesting continuously: data wins 4 cycles, fetch forced on the 5th, period 5
    @(posedge clk); #1;
    drive(1, 12'h040, 1, 0, 4'h0, 12'h012, 32'h0);
    for (int c = 0; c < 12; c++) begin
      #4;
      chk($sformatf("starve%0d_d_gnt", c), 32'(d_gnt), 32'(c % 5 != 4));
      chk($sformatf("starve%0d_if_gnt", c), 32'(if_gnt), 32'(c % 5 == 4));
      if (c > 0) begin
        chk($sformatf("starve%0d_if_rvalid", c), 32'(if_rvalid), 32'((c - 1) % 5 == 4));
        chk($sformatf("starve%0d_d_rvalid", c), 32'(d_rvalid), 32'((c - 1) % 5 != 4));
        chk($sformatf("starve%0d_d_rdata", c), d_rdata, 32'h11AA3344);
      end
      if (c == 5) chk("starve_if_rdata", if_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end

    // reset asserted between a data-read grant and its response edge drops the response
    drive(0, 12'h000, 1, 0, 4'h0, 12'h040, 32'h0);
    #2;
    chk("mid_d_gnt", 32'(d_gnt), 1);
    reset_n = 0;
    #1;
    chk("mid_d_gnt_rst", 32'(d_gnt), 0);
    chk("mid_d_rdata_rst", d_rdata, 0);
    @(posedge clk); #1;
    drive(0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0);
    #4;
    chk("mid_d_rvalid", 32'(d_rvalid), 0);
    chk("mid_d_rdata", d_rdata, 0);
    @(posedge clk); #1;
    reset_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #5;
      chk("post_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
      chk("post_rdata", if_rdata | d_rdata, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
